// File: rtl/salamander_pkg.sv
// Shared types and constants for the main-CPU ROM read server.
package salamander_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_P,
    WAIT_D
  } fsm_state_t;

  localparam int PROG_AW    = 16;
  localparam int DATA_AW    = 17;
  localparam int ROM_DW     = 16;
  localparam int MEM_AW_DEF = 22;

  localparam logic [MEM_AW_DEF-1:0] PROG_BASE_DEF = 22'h000000;
  localparam logic [MEM_AW_DEF-1:0] DATA_BASE_DEF = 22'h010000;

endpackage

// File: rtl/salamander_rom_tag_slot.sv
// One-word tagged holding register for a single ROM read channel, with a
// per-channel overrun counter that runs while the channel is missing.
module salamander_rom_tag_slot
  import salamander_pkg::*;
#(
  parameter int AW      = 16,
  parameter int TIMEOUT = 6
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              flush,
  input  logic              rdrq,
  input  logic [AW-1:0]     addr,
  input  logic              fill,
  input  logic              fill_stale,
  input  logic [AW-1:0]     fill_tag,
  input  logic [ROM_DW-1:0] fill_data,
  output logic [ROM_DW-1:0] data,
  output logic              hit,
  output logic              miss,
  output logic              late
);

  localparam int            CW      = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT + 1);

  logic [AW-1:0]     tag_reg;
  logic              tag_valid_reg;
  logic [ROM_DW-1:0] data_reg;
  logic [CW-1:0]     cnt_reg;

  assign hit  = rdrq & tag_valid_reg & (addr == tag_reg);
  assign miss = rdrq & ~hit;
  assign late = (cnt_reg == CNT_MAX);
  assign data = data_reg;

  // A stale fill still lands data and tag; only the valid bit is withheld.
  always_ff @(posedge clk) begin
    if (srst) begin
      tag_reg       <= '0;
      tag_valid_reg <= 1'b0;
      data_reg      <= '0;
    end else begin
      if (fill) begin
        data_reg <= fill_data;
        tag_reg  <= fill_tag;
      end
      if (flush)
        tag_valid_reg <= 1'b0;
      else if (fill)
        tag_valid_reg <= ~fill_stale;
    end
  end

  always_ff @(posedge clk) begin
    if (srst)
      cnt_reg <= '0;
    else if (!miss)
      cnt_reg <= '0;
    else if (cnt_reg != CNT_MAX)
      cnt_reg <= cnt_reg + 1'b1;
  end

endmodule

// File: rtl/salamander_cpurom_server.sv
// Program/data ROM responder: arbitrates two tagged channels onto one
// external memory read port, program channel first.
module salamander_cpurom_server
  import salamander_pkg::*;
#(
  parameter int                MEM_AW    = MEM_AW_DEF,
  parameter logic [MEM_AW-1:0] PROG_BASE = MEM_AW'(PROG_BASE_DEF),
  parameter logic [MEM_AW-1:0] DATA_BASE = MEM_AW'(DATA_BASE_DEF),
  parameter int                TIMEOUT   = 6
) (
  input  logic               i_EMU_MCLK,
  input  logic               i_EMU_RST,
  input  logic               i_FLUSH,
  input  logic [PROG_AW-1:0] i_PROGROM_ADDR,
  input  logic               i_PROGROM_RDRQ,
  output logic [ROM_DW-1:0]  o_PROGROM_DATA,
  output logic               o_PROGROM_VALID,
  input  logic [DATA_AW-1:0] i_DATAROM_ADDR,
  input  logic               i_DATAROM_RDRQ,
  output logic [ROM_DW-1:0]  o_DATAROM_DATA,
  output logic               o_DATAROM_VALID,
  output logic [MEM_AW-1:0]  o_MEM_ADDR,
  output logic               o_MEM_RD,
  input  logic               i_MEM_ACK,
  input  logic [ROM_DW-1:0]  i_MEM_DATA,
  output logic               o_LATE
);

  fsm_state_t         state_reg;
  logic [DATA_AW-1:0] ftag_reg;
  logic [MEM_AW-1:0]  mem_addr_reg;
  logic               mem_rd_reg;
  logic               flush_pending_reg;
  logic               late_reg;

  logic p_miss, d_miss, p_late, d_late;
  logic fill_p, fill_d, fill_stale;

  assign fill_p     = (state_reg == WAIT_P) & i_MEM_ACK;
  assign fill_d     = (state_reg == WAIT_D) & i_MEM_ACK;
  assign fill_stale = flush_pending_reg | i_FLUSH;

  salamander_rom_tag_slot #(.AW(PROG_AW), .TIMEOUT(TIMEOUT)) u_prog_slot (
    .clk        (i_EMU_MCLK),
    .srst       (i_EMU_RST),
    .flush      (i_FLUSH),
    .rdrq       (i_PROGROM_RDRQ),
    .addr       (i_PROGROM_ADDR),
    .fill       (fill_p),
    .fill_stale (fill_stale),
    .fill_tag   (ftag_reg[PROG_AW-1:0]),
    .fill_data  (i_MEM_DATA),
    .data       (o_PROGROM_DATA),
    .hit        (o_PROGROM_VALID),
    .miss       (p_miss),
    .late       (p_late)
  );

  salamander_rom_tag_slot #(.AW(DATA_AW), .TIMEOUT(TIMEOUT)) u_data_slot (
    .clk        (i_EMU_MCLK),
    .srst       (i_EMU_RST),
    .flush      (i_FLUSH),
    .rdrq       (i_DATAROM_RDRQ),
    .addr       (i_DATAROM_ADDR),
    .fill       (fill_d),
    .fill_stale (fill_stale),
    .fill_tag   (ftag_reg),
    .fill_data  (i_MEM_DATA),
    .data       (o_DATAROM_DATA),
    .hit        (o_DATAROM_VALID),
    .miss       (d_miss),
    .late       (d_late)
  );

  assign o_MEM_ADDR = mem_addr_reg;
  assign o_MEM_RD   = mem_rd_reg;
  assign o_LATE     = late_reg;

  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_RST) begin
      state_reg         <= IDLE;
      ftag_reg          <= '0;
      mem_addr_reg      <= '0;
      mem_rd_reg        <= 1'b0;
      flush_pending_reg <= 1'b0;
      late_reg          <= 1'b0;
    end else begin
      if (p_late || d_late)
        late_reg <= 1'b1;

      // A flush during a fetch poisons only that fetch's fill.
      if (state_reg != IDLE) begin
        if (i_MEM_ACK)
          flush_pending_reg <= 1'b0;
        else if (i_FLUSH)
          flush_pending_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (p_miss) begin
            ftag_reg     <= {1'b0, i_PROGROM_ADDR};
            mem_addr_reg <= PROG_BASE + MEM_AW'(i_PROGROM_ADDR);
            mem_rd_reg   <= 1'b1;
            state_reg    <= WAIT_P;
          end else if (d_miss) begin
            ftag_reg     <= i_DATAROM_ADDR;
            mem_addr_reg <= DATA_BASE + MEM_AW'(i_DATAROM_ADDR);
            mem_rd_reg   <= 1'b1;
            state_reg    <= WAIT_D;
          end
        end
        WAIT_P, WAIT_D: begin
          if (i_MEM_ACK) begin
            mem_rd_reg <= 1'b0;
            state_reg  <= IDLE;
          end
        end
        default: begin
          mem_rd_reg <= 1'b0;
          state_reg  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_salamander_cpurom_server.sv
// Bench for the ROM read server: directed scenarios plus randomized
// request traffic checked against a one-word-per-channel cache model.
module tb_salamander_cpurom_server;

  localparam logic [21:0] PB = 22'h000000;
  localparam logic [21:0] DB = 22'h3F0000;

  logic        mclk = 1'b0;
  logic        srst;
  logic        flush;
  logic [15:0] p_addr;
  logic        p_rdrq;
  logic [15:0] p_data;
  logic        p_valid;
  logic [16:0] d_addr;
  logic        d_rdrq;
  logic [15:0] d_data;
  logic        d_valid;
  logic [21:0] mem_addr;
  logic        mem_rd;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic        late;

  always #5 mclk = ~mclk;

  salamander_cpurom_server #(
    .MEM_AW    (22),
    .PROG_BASE (PB),
    .DATA_BASE (DB),
    .TIMEOUT   (6)
  ) dut (
    .i_EMU_MCLK      (mclk),
    .i_EMU_RST       (srst),
    .i_FLUSH         (flush),
    .i_PROGROM_ADDR  (p_addr),
    .i_PROGROM_RDRQ  (p_rdrq),
    .o_PROGROM_DATA  (p_data),
    .o_PROGROM_VALID (p_valid),
    .i_DATAROM_ADDR  (d_addr),
    .i_DATAROM_RDRQ  (d_rdrq),
    .o_DATAROM_DATA  (d_data),
    .o_DATAROM_VALID (d_valid),
    .o_MEM_ADDR      (mem_addr),
    .o_MEM_RD        (mem_rd),
    .i_MEM_ACK       (mem_ack),
    .i_MEM_DATA      (mem_data),
    .o_LATE          (late)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_lat = 2;
  logic [21:0] issue_addr_q[$];
  int          issue_cyc_q[$];
  int          ack_cyc_q[$];

  always @(posedge mclk) cyc <= cyc + 1;

  function automatic logic [15:0] mem_word(input logic [21:0] a);
    if (a == 22'h0) return 16'h4E71;
    return a[15:0] ^ {a[21:16], a[21:12]} ^ 16'hA5C3;
  endfunction

  function automatic logic [21:0] p_mem(input logic [15:0] a);
    logic [21:0] s;
    s = PB + 22'(a);
    return s;
  endfunction

  function automatic logic [21:0] d_mem(input logic [16:0] a);
    logic [21:0] s;
    s = DB + 22'(a);
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic wait_valid(input bit ch, input int bound, output int n);
    n = 0;
    @(negedge mclk);
    while (!(ch ? d_valid : p_valid) && n < bound) begin
      @(negedge mclk);
      n++;
    end
    check(ch ? "wait_d_valid" : "wait_p_valid", 32'(ch ? d_valid : p_valid), 32'd1);
  endtask

  // External memory: acks mem_lat cycles after each issue, logs every read.
  initial begin
    int  wait_cnt;
    logic rd_prev;
    mem_ack  = 1'b0;
    mem_data = '0;
    wait_cnt = 0;
    rd_prev  = 1'b0;
    forever begin
      step();
      if (mem_rd && !rd_prev) begin
        issue_addr_q.push_back(mem_addr);
        issue_cyc_q.push_back(cyc);
        $display("mem read issue addr=%06h cyc=%0d", mem_addr, cyc);
      end
      rd_prev = mem_rd;
      if (mem_ack) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end else if (mem_rd) begin
        wait_cnt++;
        if (wait_cnt >= mem_lat) begin
          mem_ack  = 1'b1;
          mem_data = mem_word(mem_addr);
          ack_cyc_q.push_back(cyc + 1);
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    int n, n0;
    logic [15:0] p_pool[4];
    logic [16:0] d_pool[4];
    bit          mv[2];
    logic [16:0] mt[2];
    bit          rp, rd, hp, hd, done;

    p_pool = '{16'h0001, 16'h0123, 16'hFFFF, 16'h8000};
    d_pool = '{17'h00456, 17'h1FFFF, 17'h10000, 17'h00001};

    srst = 1'b1; flush = 1'b0;
    p_addr = '0; p_rdrq = 1'b0; d_addr = '0; d_rdrq = 1'b0;
    repeat (3) step();
    @(negedge mclk);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_late", 32'(late), 32'd0);
    check("rst_p_data", 32'(p_data), 32'd0);
    check("rst_d_data", 32'(d_data), 32'd0);

    // First program fetch: three cycles from request to valid.
    step();
    srst = 1'b0; p_rdrq = 1'b1; p_addr = 16'h0000;
    #1;
    check("first_p_valid_now", 32'(p_valid), 32'd0);
    wait_valid(1'b0, 20, n);
    check("first_latency", 32'(n), 32'd3);
    check("first_p_data", 32'(p_data), 32'h4E71);
    check("first_issue_cnt", 32'(issue_addr_q.size()), 32'd1);
    check("first_mem_addr", 32'(issue_addr_q[0]), 32'h000000);

    // Repeat request of the same word is a zero-cycle hit.
    step(); p_rdrq = 1'b0;
    step(); p_rdrq = 1'b1;
    wait_valid(1'b0, 20, n);
    check("rehit_latency", 32'(n), 32'd0);
    check("rehit_issue_cnt", 32'(issue_addr_q.size()), 32'd1);
    check("rehit_p_data", 32'(p_data), 32'h4E71);

    // Data channel top address wraps modulo 2^22.
    step(); p_rdrq = 1'b0; d_rdrq = 1'b1; d_addr = 17'h1FFFF;
    wait_valid(1'b1, 20, n);
    check("wrap_mem_addr", 32'(issue_addr_q[issue_addr_q.size()-1]), 32'h00FFFF);
    check("wrap_d_data", 32'(d_data), 32'(mem_word(22'h00FFFF)));

    // Simultaneous misses: program first, data the cycle after IDLE.
    step(); d_rdrq = 1'b0;
    step();
    n0 = issue_addr_q.size();
    p_rdrq = 1'b1; p_addr = 16'h0123; d_rdrq = 1'b1; d_addr = 17'h00456;
    wait_valid(1'b0, 20, n);
    wait_valid(1'b1, 20, n);
    check("both_first_addr", 32'(issue_addr_q[n0]), 32'(p_mem(16'h0123)));
    check("both_second_addr", 32'(issue_addr_q[n0+1]), 32'(d_mem(17'h00456)));
    check("both_d_issue_cyc", 32'(issue_cyc_q[n0+1]), 32'(ack_cyc_q[n0] + 1));
    check("both_p_data", 32'(p_data), 32'(mem_word(p_mem(16'h0123))));
    check("both_d_data", 32'(d_data), 32'(mem_word(d_mem(17'h00456))));
    check("both_p_still_valid", 32'(p_valid), 32'd1);

    // Randomized traffic against a one-word-per-channel cache model.
    step(); p_rdrq = 1'b0; d_rdrq = 1'b0; flush = 1'b1;
    step(); flush = 1'b0;
    mv[0] = 1'b0; mv[1] = 1'b0; mt[0] = '0; mt[1] = '0;
    for (int it = 0; it < 30; it++) begin
      step();
      mem_lat = $urandom_range(1, 2);
      rp = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      if (!rp && !rd) rp = 1'b1;
      p_addr = p_pool[$urandom_range(0, 3)];
      d_addr = d_pool[$urandom_range(0, 3)];
      p_rdrq = rp; d_rdrq = rd;
      hp = mv[0] && (mt[0] == 17'(p_addr));
      hd = mv[1] && (mt[1] == d_addr);
      n0 = issue_addr_q.size();
      @(negedge mclk);
      if (rp) check("rnd_p_hit_now", 32'(p_valid), 32'(hp));
      if (rd) check("rnd_d_hit_now", 32'(d_valid), 32'(hd));
      n = 0;
      done = (!rp || p_valid) && (!rd || d_valid);
      while (!done && n < 30) begin
        @(negedge mclk);
        n++;
        done = (!rp || p_valid) && (!rd || d_valid);
      end
      check("rnd_served", 32'(done), 32'd1);
      if (rp) check("rnd_p_data", 32'(p_data), 32'(mem_word(p_mem(p_addr))));
      if (rd) check("rnd_d_data", 32'(d_data), 32'(mem_word(d_mem(d_addr))));
      check("rnd_fetches", 32'(issue_addr_q.size() - n0),
            32'(int'(rp && !hp) + int'(rd && !hd)));
      if (rp) begin mv[0] = 1'b1; mt[0] = 17'(p_addr); end
      if (rd) begin mv[1] = 1'b1; mt[1] = d_addr; end
      step(); p_rdrq = 1'b0; d_rdrq = 1'b0;
      if ($urandom_range(0, 5) == 0) begin
        flush = 1'b1;
        step(); flush = 1'b0;
        mv[0] = 1'b0; mv[1] = 1'b0;
      end
    end
    check("rnd_no_late", 32'(late), 32'd0);

    // Address change mid-fetch: old fill lands, channel refetches.
    mem_lat = 2;
    step(); p_rdrq = 1'b1; p_addr = 16'h0010;
    n0 = issue_addr_q.size();
    step(); p_addr = 16'h0011;
    wait_valid(1'b0, 20, n);
    check("chg_latency", 32'(n), 32'd5);
    check("chg_first_addr", 32'(issue_addr_q[n0]), 32'(p_mem(16'h0010)));
    check("chg_second_addr", 32'(issue_addr_q[n0+1]), 32'(p_mem(16'h0011)));
    check("chg_issue_cnt", 32'(issue_addr_q.size() - n0), 32'd2);
    check("chg_p_data", 32'(p_data), 32'(mem_word(p_mem(16'h0011))));

    // Flush coincident with ack: fill stays invalid, refetch follows.
    step(); p_addr = 16'h0020;
    n0 = issue_addr_q.size();
    n = 0;
    @(negedge mclk);
    while (!mem_ack && n < 20) begin
      @(negedge mclk);
      n++;
    end
    check("flush_ack_seen", 32'(mem_ack), 32'd1);
    flush = 1'b1;
    step(); flush = 1'b0;
    @(negedge mclk);
    check("flush_ack_p_valid", 32'(p_valid), 32'd0);
    wait_valid(1'b0, 20, n);
    check("flush_refetch_cnt", 32'(issue_addr_q.size() - n0), 32'd2);
    check("flush_p_data", 32'(p_data), 32'(mem_word(p_mem(16'h0020))));

    // Slow memory trips the sticky overrun flag.
    mem_lat = 10;
    step(); p_addr = 16'h0030;
    wait_valid(1'b0, 30, n);
    check("slow_p_data", 32'(p_data), 32'(mem_word(p_mem(16'h0030))));
    check("slow_late", 32'(late), 32'd1);
    step(); p_rdrq = 1'b0; flush = 1'b1;
    step(); flush = 1'b0;
    @(negedge mclk);
    check("late_after_flush", 32'(late), 32'd1);

    // Reset in the middle of a fetch drops the strobe and the flag.
    step(); p_rdrq = 1'b1; p_addr = 16'h0050;
    step(); step();
    @(negedge mclk);
    check("midfetch_rd_high", 32'(mem_rd), 32'd1);
    srst = 1'b1;
    step();
    @(negedge mclk);
    check("rst_mid_rd", 32'(mem_rd), 32'd0);
    check("rst_mid_late", 32'(late), 32'd0);
    check("rst_mid_p_data", 32'(p_data), 32'd0);
    step(); srst = 1'b0; p_rdrq = 1'b0;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
